stop_watch_ctrl: RTL and testbench

Control sequencer between the board push-buttons, the BCD stopwatch counter and the 7-seg display mux. It debounces and edge-detects two raw buttons, then runs a start/stop/clear/lap state machine. The machine drives the counter's go/clr inputs. It also drives the digits the display shows: live counter digits, or a frozen lap snapshot.

---
 rtl/stop_watch_ctrl.sv | 162 ++++++++++++++++
 tb/tb_stop_watch_ctrl.sv | 250 +++++++++++++++++++++++++
 2 files changed

// File: rtl/stop_watch_ctrl.sv
// Stopwatch control: debounces and edge-detects the go/clr buttons and sequences start/stop/clear/lap.
// Define STOP_WATCH_LAP_EN to build the LAP state, the snapshot register and the lap output.
module stop_watch_ctrl #(
  parameter int unsigned DB_CNT = 1_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_go,
  input  logic       btn_clr,
  input  logic [3:0] d2,
  input  logic [3:0] d1,
  input  logic [3:0] d0,
  output logic       go,
  output logic       clr,
  output logic [3:0] q2,
  output logic [3:0] q1,
  output logic [3:0] q0,
  output logic       run,
  output logic       lap
);

  localparam int unsigned   CW       = $clog2(DB_CNT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DB_CNT - 1);

  // Bit 0 is the go button, bit 1 the clr button.
  logic [1:0]    btn;
  logic [1:0]    sync1_q, sync2_q, lvl_q, prev_q, arm_q, p_q;
  logic [CW-1:0] cnt_q [2];
  logic [1:0]    warm_q;
  logic          p_go, p_clr;

  assign btn = {btn_clr, btn_go};

  // arm_q withholds press events until the synced button has been seen released after reset,
  // so a button held through reset cannot fire on its own.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= '0;
      sync2_q <= '0;
      lvl_q   <= '0;
      prev_q  <= '0;
      arm_q   <= '0;
      p_q     <= '0;
      warm_q  <= '0;
      for (int unsigned i = 0; i < 2; i++) cnt_q[i] <= '0;
    end else begin
      sync1_q <= btn;
      sync2_q <= sync1_q;
      prev_q  <= lvl_q;
      p_q     <= lvl_q & ~prev_q & arm_q;
      if (warm_q != 2'd2) warm_q <= warm_q + 2'd1;
      if (warm_q == 2'd2) arm_q <= arm_q | ~sync2_q;
      for (int unsigned i = 0; i < 2; i++) begin
        if (sync2_q[i] == lvl_q[i]) begin
          cnt_q[i] <= '0;
        end else if (cnt_q[i] == CNT_LAST) begin
          cnt_q[i] <= '0;
          lvl_q[i] <= sync2_q[i];
        end else begin
          cnt_q[i] <= cnt_q[i] + CW'(1);
        end
      end
    end
  end

  assign p_go  = p_q[0];
  assign p_clr = p_q[1] & ~p_q[0];

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_PAUSE
`ifdef STOP_WATCH_LAP_EN
    , S_LAP
`endif
  } state_t;

  state_t      state_q, state_d;
  logic        go_q, go_d, clr_q, clr_d, run_q, run_d;
  logic [11:0] q_q, q_d, live;
`ifdef STOP_WATCH_LAP_EN
  logic        lap_q, lap_d;
  logic [11:0] snap_q, snap_d;
`endif

  assign live = {d2, d1, d0};

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      go_q    <= 1'b0;
      clr_q   <= 1'b0;
      run_q   <= 1'b0;
      q_q     <= '0;
`ifdef STOP_WATCH_LAP_EN
      lap_q   <= 1'b0;
      snap_q  <= '0;
`endif
    end else begin
      state_q <= state_d;
      go_q    <= go_d;
      clr_q   <= clr_d;
      run_q   <= run_d;
      q_q     <= q_d;
`ifdef STOP_WATCH_LAP_EN
      lap_q   <= lap_d;
      snap_q  <= snap_d;
`endif
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE, S_PAUSE: begin
        if (p_go)       state_d = S_RUN;
        else if (p_clr) state_d = S_IDLE;
      end
      S_RUN: begin
        if (p_go)       state_d = S_PAUSE;
`ifdef STOP_WATCH_LAP_EN
        else if (p_clr) state_d = S_LAP;
`endif
      end
`ifdef STOP_WATCH_LAP_EN
      S_LAP: begin
        if (p_go)       state_d = S_PAUSE;
        else if (p_clr) state_d = S_RUN;
      end
`endif
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    go_d  = (state_d == S_RUN);
`ifdef STOP_WATCH_LAP_EN
    go_d  = go_d || (state_d == S_LAP);
`endif
    run_d = go_d;
    clr_d = p_clr && ((state_q == S_IDLE) || (state_q == S_PAUSE));
`ifdef STOP_WATCH_LAP_EN
    lap_d  = (state_d == S_LAP);
    snap_d = snap_q;
    if ((state_q == S_RUN) && p_clr) snap_d = live;
    q_d    = lap_q ? snap_q : live;
`else
    q_d    = live;
`endif
  end

  assign go           = go_q;
  assign clr          = clr_q;
  assign run          = run_q;
  assign {q2, q1, q0} = q_q;
`ifdef STOP_WATCH_LAP_EN
  assign lap          = lap_q;
`else
  assign lap          = 1'b0;
`endif

endmodule

// File: tb/tb_stop_watch_ctrl.sv
// Bench for stop_watch_ctrl: directed scenarios plus random button activity against a reference model.
module tb_stop_watch_ctrl;

  localparam int unsigned DB = 4;
`ifdef STOP_WATCH_LAP_EN
  localparam bit LAP_EN = 1'b1;
`else
  localparam bit LAP_EN = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset, btn_go, btn_clr;
  logic [3:0] d2, d1, d0;
  logic       go, clr, run, lap;
  logic [3:0] q2, q1, q0;

  always #5 clk = ~clk;

  stop_watch_ctrl #(.DB_CNT(DB)) dut (
    .clk(clk), .reset(reset), .btn_go(btn_go), .btn_clr(btn_clr),
    .d2(d2), .d1(d1), .d0(d0),
    .go(go), .clr(clr), .q2(q2), .q1(q1), .q0(q0), .run(run), .lap(lap)
  );

  int unsigned n_cmp = 0, n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: raw samples per edge, button level accepted after DB edges of disagreement,
  // press usable two edges later; the machine is just "running" and "frozen" flags.
  bit          hist_g [65536];
  bit          hist_c [65536];
  int          e = -1;
  int          r_first = 0;
  bit          m_valid = 1'b0;
  bit          lvl_g, lvl_c, pend_g, pend_c, evt_g, evt_c, arm_g, arm_c;
  bit          running, frozen, clr_e;
  logic [11:0] snap_e, q_e;

  function automatic bit sync_at(input bit c, input int j);
    if (j - 2 < r_first) return 1'b0;
    return c ? hist_c[j-2] : hist_g[j-2];
  endfunction

  function automatic bit flips(input bit c, input bit lvl);
    if (e - int'(DB) + 1 < r_first) return 1'b0;
    for (int k = 0; k < int'(DB); k++)
      if (sync_at(c, e - k) == lvl) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_step();
    bit          ag, ac, fg, fc;
    logic [11:0] dv;
    e++;
    dv = {d2, d1, d0};
    if (reset) begin
      r_first = e + 1;
      m_valid = 1'b1;
      {lvl_g, lvl_c, pend_g, pend_c, evt_g, evt_c, arm_g, arm_c} = '0;
      running = 1'b0;
      frozen  = 1'b0;
      clr_e   = 1'b0;
      snap_e  = '0;
      q_e     = '0;
    end else begin
      hist_g[e] = btn_go;
      hist_c[e] = btn_clr;
      ag = evt_g;
      ac = evt_c & ~evt_g;
      evt_g = pend_g & arm_g;
      evt_c = pend_c & arm_c;
      if (e - 2 >= r_first) begin
        if (!sync_at(1'b0, e)) arm_g = 1'b1;
        if (!sync_at(1'b1, e)) arm_c = 1'b1;
      end
      fg = flips(1'b0, lvl_g);
      fc = flips(1'b1, lvl_c);
      pend_g = fg & ~lvl_g;
      pend_c = fc & ~lvl_c;
      if (fg) lvl_g = ~lvl_g;
      if (fc) lvl_c = ~lvl_c;
      q_e   = frozen ? snap_e : dv;
      clr_e = 1'b0;
      if (ag) begin
        if (running) begin
          running = 1'b0;
          frozen  = 1'b0;
        end else begin
          running = 1'b1;
        end
      end else if (ac) begin
        if (!running) clr_e = 1'b1;
        else if (LAP_EN) begin
          if (!frozen) snap_e = dv;
          frozen = ~frozen;
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  initial forever begin
    @(negedge clk);
    if (m_valid) begin
      check("go",  32'(go),  32'(running));
      check("run", 32'(run), 32'(running));
      check("lap", 32'(lap), 32'(frozen));
      check("clr", 32'(clr), 32'(clr_e));
      check("q",   32'({q2, q1, q0}), 32'(q_e));
    end
  end

  bit rnd_d = 1'b0;

  task automatic cyc(input int unsigned n);
    repeat (n) begin
      @(negedge clk);
      if (rnd_d) begin
        d2 = 4'($urandom_range(0, 9));
        d1 = 4'($urandom_range(0, 9));
        d0 = 4'($urandom_range(0, 9));
      end
    end
  endtask

  task automatic set_btn(input bit g, input bit c, input bit v);
    if (g) btn_go  = v;
    if (c) btn_clr = v;
  endtask

  task automatic press(input bit g, input bit c, input int unsigned bounces,
                       input int unsigned hold, input int unsigned gap);
    for (int unsigned i = 0; i < bounces; i++) begin
      set_btn(g, c, 1'b1); cyc(1);
      set_btn(g, c, 1'b0); cyc(1);
    end
    set_btn(g, c, 1'b1); cyc(hold);
    set_btn(g, c, 1'b0); cyc(gap);
  endtask

  task automatic count_clr(input int unsigned n, output int unsigned cnt);
    cnt = 0;
    repeat (n) begin
      cyc(1);
      if (clr === 1'b1) cnt++;
    end
  endtask

  int unsigned pulses, sel;

  initial begin
    reset = 1'b1; btn_go = 1'b0; btn_clr = 1'b0;
    {d2, d1, d0} = 12'h000;
    cyc(3);
    check("rst_go",  32'(go),  32'd0);
    check("rst_clr", 32'(clr), 32'd0);
    check("rst_run", 32'(run), 32'd0);
    check("rst_lap", 32'(lap), 32'd0);
    check("rst_q",   32'({q2, q1, q0}), 32'd0);
    reset = 1'b0;
    cyc(6);

    // Bouncy go press: go rises 2+DB+1+1 edges after the final stable level.
    btn_go = 1'b1; cyc(1); btn_go = 1'b0; cyc(1); btn_go = 1'b1;
    cyc(7);
    check("go_latency_early", 32'(go), 32'd0);
    cyc(1);
    check("go_latency", 32'(go), 32'd1);
    check("run_on", 32'(run), 32'd1);
    cyc(2);
    btn_go = 1'b0;
    {d2, d1, d0} = 12'h345;
    cyc(12);

    // Lap freeze and release
    btn_clr = 1'b1; cyc(10);
    check("lap_set", 32'(lap), 32'(LAP_EN));
    {d2, d1, d0} = 12'h350;
    cyc(3);
    check("lap_freeze_q", 32'({q2, q1, q0}), LAP_EN ? 32'h345 : 32'h350);
    btn_clr = 1'b0; cyc(12);
    btn_clr = 1'b1; cyc(10);
    check("lap_release", 32'(lap), 32'd0);
    check("run_kept", 32'(run), 32'd1);
    btn_clr = 1'b0; cyc(12);
    check("q_tracks", 32'({q2, q1, q0}), 32'h350);

    // Pause then clear
    press(1'b1, 1'b0, 0, 10, 12);
    check("pause_go", 32'(go), 32'd0);
    btn_clr = 1'b1;
    count_clr(20, pulses);
    check("clr_pulse", pulses, 32'd1);
    btn_clr = 1'b0; cyc(12);
    check("idle_go", 32'(go), 32'd0);

    // Simultaneous events in RUN: go wins, clear discarded
    press(1'b1, 1'b0, 0, 10, 12);
    check("rerun", 32'(run), 32'd1);
    btn_go = 1'b1; btn_clr = 1'b1;
    count_clr(12, pulses);
    check("simul_go", 32'(go), 32'd0);
    check("simul_noclr", pulses, 32'd0);
    check("simul_nolap", 32'(lap), 32'd0);
    btn_go = 1'b0; btn_clr = 1'b0; cyc(12);

    // Reset during LAP with go held: no event until released and pressed again
    press(1'b1, 1'b0, 0, 10, 12);
    press(1'b0, 1'b1, 0, 10, 12);
    btn_go = 1'b1; cyc(2);
    reset = 1'b1; cyc(3);
    check("rst_mid_lap", 32'(lap), 32'd0);
    check("rst_mid_run", 32'(run), 32'd0);
    reset = 1'b0; cyc(20);
    check("held_no_event", 32'(run), 32'd0);
    btn_go = 1'b0; cyc(12);
    btn_go = 1'b1; cyc(10);
    check("repress_run", 32'(run), 32'd1);
    btn_go = 1'b0; cyc(12);

    // Random button activity with random digits and occasional reset
    rnd_d = 1'b1;
    for (int unsigned it = 0; it < 150; it++) begin
      if ($urandom_range(0, 29) == 0) begin
        reset = 1'b1;
        cyc($urandom_range(1, 3));
        reset = 1'b0;
      end
      sel = $urandom_range(0, 3);
      press(sel != 1, sel == 1 || sel == 2, $urandom_range(0, 3),
            $urandom_range(0, 12), $urandom_range(0, 12));
    end
    cyc(20);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
